prog_seq: RTL and testbench
===========================

# prog_seq

Program sequencer sitting directly in front of the program memory ROM: it owns the program counter, drives the ROM address, receives the 18-bit instruction word back in the same cycle, and resolves control flow itself. Control-flow instructions are BRZ, JMP (call) and RET; everything else is issued one cycle later to the execute stage. The sequencer also implements the processor start/ready handshake around the idle loop at address 0.

## Interface
- `AW`, 13: program address width.
- `IW`, 18: instruction width.
- `RSD`, 4: return-stack depth (entries).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  processor start request.
- `ready`  out  1  processor ready; combinational, `pc == 0`.
- `padr`  out  AW  program address to ROM; equals `pc`.
- `instr`  in  IW  ROM data for `padr`, valid in the same cycle.
- `brz_reg`  out  4  register index for the BRZ zero test; `instr[3:0]`, combinational.
- `brz_zero`  in  1  register file reports `R[brz_reg] == 0` in the same cycle. R0 always reads zero.
- `stall`  in  1  execute stage cannot accept; freezes the sequencer.
- `issue_valid`  out  1  registered; an instruction is presented to execute.
- `issue_instr`  out  IW  registered instruction word.
- `rs_err`  out  1  sticky; set when RET is executed on an empty return stack.

## Operation
- Decode fields:
  - `op = instr[17:13]`
  - BRZ `11000`: `off = instr[12:4]`, 9-bit two's complement; register is `instr[3:0]`.
  - JMP `11010`: `tgt = instr[12:0]`.
  - RET `11100`.
- Next-PC priority, evaluated only when `stall == 0`:
  1. `start && pc == 0`: pc ← 1. Overrides the instruction at address 0.
  2. BRZ with `brz_zero == 1`: pc ← pc + sext(off), modulo 2^AW.
  3. BRZ with `brz_zero == 0`: pc ← pc + 1.
  4. JMP with `tgt == 0`: pc ← 0 and the return stack is flushed (sp ← 0). Nothing is pushed.
  5. JMP with `tgt != 0`: push pc + 1, then pc ← tgt.
  6. RET with stack non-empty: pc ← pop.
  7. RET with stack empty: pc ← 0 and `rs_err` ← 1.
  8. Any other opcode: pc ← pc + 1, wrapping 2^AW − 1 → 0.
- `start` while `pc != 0` is ignored and is not remembered.
- Return stack is a circular buffer of RSD entries with an occupancy count capped at RSD.
  - A push when full overwrites the oldest entry; the count stays at RSD.
  - A pop when the count is 0 is the empty case (rule 7).
- Issue rules:
  - Non-control opcodes set `issue_valid ← 1` and `issue_instr ← instr` at the edge.
  - Control-flow opcodes set `issue_valid ← 0`; `issue_instr` holds its old value.
  - The start override (rule 1) issues nothing.
- Stall: when `stall == 1`, pc, return stack, `issue_valid`, `issue_instr` and `rs_err` all hold. `start` is ignored.
- Reset values:
  - pc = 0, so `padr = 0` and `ready = 1`.
  - sp = 0 and count = 0.
  - `issue_valid = 0`, `issue_instr = 0`, `rs_err = 0`.
- Reset mid-operation discards the return stack and any pending issue. It takes priority over `start` and `stall`.

## Timing
- `padr`, `ready` and `brz_reg` are combinational from state. `instr` and `brz_zero` must settle within the same cycle.
- Control-flow resolution: the target appears on `padr` the cycle after the control instruction is on `padr`. There are no delay slots and no bubbles beyond the non-issued control instruction itself.
- Issue latency: instruction on `padr` in cycle N appears on `issue_*` in cycle N+1.
- Throughput: one instruction per unstalled cycle.
- `stall` is sampled every edge. One cycle of stall holds exactly one cycle.
- Idle loop: with BRZ R0,0 at address 0, pc stays 0 indefinitely and `ready` stays 1.

## Test plan
- **Reset and idle loop.** Assert `rst` 2 cycles; ROM[0] = BRZ R0,0; `brz_zero = 1`; run 5 cycles -> `padr = 0`, `ready = 1`, `issue_valid = 0`, `rs_err = 0` throughout.
- **Start and issue.** Pulse `start` 1 cycle at idle; ROM[1] = LD R0,R1 (0x20020) -> next cycle `padr = 1` and `ready = 0`; following cycle `issue_valid = 1`, `issue_instr = 0x20020`, `padr = 2`.
- **Call and return.** JMP 200 at address 14 -> `padr = 200` next cycle, `issue_valid = 0`. Run to RET at 207 -> `padr = 15` next cycle, stack empty again.
- **Branch loop.** At 205, BRZ R0,−3 -> `padr = 202`. At 203, BRZ R6,+4: with `brz_zero = 0` -> `padr = 204`; with `brz_zero = 1` -> `padr = 207`.
- **Stall.** Assert `stall` 3 cycles mid-stream, including once while a JMP is on `padr` -> `padr`, `issue_*` and the return stack are frozen. JMP takes effect the cycle after stall drops.
- **Stack overflow and underflow** (RSD = 4).
  - 5 nested JMPs from addresses 10, 20, 30, 40, 50, then 5 RETs -> returns to 51, 41, 31, 21, then pc = 0 with `rs_err = 1`, held until `rst`.
  - `start` asserted while pc ≠ 0 -> no effect.

Source files
------------

// File: rtl/prog_seq_if.sv
// Bus between the program sequencer, its program ROM, the BRZ register
// read port and the execute stage.
interface prog_seq_if #(
  parameter int AW  = 13,
  parameter int IW  = 18,
  parameter int RSD = 4
);
  // Issue handshake: issue_valid/issue_instr describe the instruction
  // presented to execute. While stall is high the execute stage refuses
  // it, and the sequencer freezes completely, so the presented word stays
  // stable. An instruction counts as accepted on a rising edge where
  // issue_valid is high and stall is low.
  logic                     start;
  logic                     ready;
  logic [AW-1:0]            padr;
  logic [IW-1:0]            instr;
  logic [3:0]               brz_reg;
  logic                     brz_zero;
  logic                     stall;
  logic                     issue_valid;
  logic [IW-1:0]            issue_instr;
  logic                     rs_err;
  logic [$clog2(RSD+1)-1:0] rs_count;

  modport master (
    input  start, instr, brz_zero, stall,
    output ready, padr, brz_reg, issue_valid, issue_instr, rs_err, rs_count
  );

  modport slave (
    output start, instr, brz_zero, stall,
    input  ready, padr, brz_reg, issue_valid, issue_instr, rs_err, rs_count
  );
endinterface

// File: rtl/prog_seq.sv
// Program sequencer: owns the PC, resolves BRZ/JMP/RET against the ROM word
// in the same cycle and issues everything else one cycle later.
module prog_seq #(
  parameter int AW  = 13,
  parameter int IW  = 18,
  parameter int RSD = 4
) (
  input logic        clk,
  input logic        rst,
  prog_seq_if.master bus
);
  localparam int SPW = (RSD > 1) ? $clog2(RSD) : 1;
  localparam int CW  = $clog2(RSD + 1);

  localparam logic [4:0] OP_BRZ = 5'b11000;
  localparam logic [4:0] OP_JMP = 5'b11010;
  localparam logic [4:0] OP_RET = 5'b11100;

  typedef enum logic [3:0] {
    ACT_HOLD,
    ACT_START,
    ACT_BRANCH,
    ACT_SKIP,
    ACT_FLUSH,
    ACT_CALL,
    ACT_RETURN,
    ACT_UNDERFLOW,
    ACT_ISSUE
  } act_e;

  logic [AW-1:0]  pc, pc_nxt;
  logic [AW-1:0]  rs_mem [RSD];
  logic [SPW-1:0] sp, sp_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           iv, iv_nxt;
  logic [IW-1:0]  ii, ii_nxt;
  logic           err, err_nxt;
  logic           push;
  act_e           act;

  logic [4:0]     op;
  logic [8:0]     off;
  logic [AW-1:0]  off_ext;
  logic [AW-1:0]  tgt;
  logic [AW-1:0]  pc_inc;
  logic [SPW-1:0] sp_inc;
  logic [SPW-1:0] sp_dec;

  assign op      = bus.instr[IW-1 -: 5];
  assign off     = bus.instr[12:4];
  assign off_ext = {{(AW-9){off[8]}}, off};
  assign tgt     = bus.instr[AW-1:0];
  assign pc_inc  = pc + 1'b1;

  // sp always points at the next free slot; when full that slot holds the
  // oldest entry, so a push there overwrites it.
  assign sp_inc = (sp == SPW'(RSD - 1)) ? '0 : sp + 1'b1;
  assign sp_dec = (sp == '0) ? SPW'(RSD - 1) : sp - 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      sp  <= '0;
      cnt <= '0;
      iv  <= 1'b0;
      ii  <= '0;
      err <= 1'b0;
    end else begin
      pc  <= pc_nxt;
      sp  <= sp_nxt;
      cnt <= cnt_nxt;
      iv  <= iv_nxt;
      ii  <= ii_nxt;
      err <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) rs_mem[sp] <= pc_inc;
  end

  // Action decode: start at the idle address beats whatever word sits there.
  always_comb begin
    act = ACT_HOLD;
    if (!bus.stall) begin
      if (bus.start && pc == '0) begin
        act = ACT_START;
      end else begin
        case (op)
          OP_BRZ:  act = bus.brz_zero ? ACT_BRANCH : ACT_SKIP;
          OP_JMP:  act = (tgt == '0) ? ACT_FLUSH : ACT_CALL;
          OP_RET:  act = (cnt == '0) ? ACT_UNDERFLOW : ACT_RETURN;
          default: act = ACT_ISSUE;
        endcase
      end
    end
  end

  // Next-state
  always_comb begin
    pc_nxt  = pc;
    sp_nxt  = sp;
    cnt_nxt = cnt;
    iv_nxt  = iv;
    ii_nxt  = ii;
    err_nxt = err;
    push    = 1'b0;
    case (act)
      ACT_HOLD: begin
      end
      ACT_START: begin
        pc_nxt = AW'(1);
        iv_nxt = 1'b0;
      end
      ACT_BRANCH: begin
        pc_nxt = pc + off_ext;
        iv_nxt = 1'b0;
      end
      ACT_SKIP: begin
        pc_nxt = pc_inc;
        iv_nxt = 1'b0;
      end
      ACT_FLUSH: begin
        pc_nxt  = '0;
        sp_nxt  = '0;
        cnt_nxt = '0;
        iv_nxt  = 1'b0;
      end
      ACT_CALL: begin
        push   = 1'b1;
        pc_nxt = tgt;
        sp_nxt = sp_inc;
        if (cnt != CW'(RSD)) cnt_nxt = cnt + 1'b1;
        iv_nxt = 1'b0;
      end
      ACT_RETURN: begin
        pc_nxt  = rs_mem[sp_dec];
        sp_nxt  = sp_dec;
        cnt_nxt = cnt - 1'b1;
        iv_nxt  = 1'b0;
      end
      ACT_UNDERFLOW: begin
        pc_nxt  = '0;
        err_nxt = 1'b1;
        iv_nxt  = 1'b0;
      end
      ACT_ISSUE: begin
        pc_nxt = pc_inc;
        iv_nxt = 1'b1;
        ii_nxt = bus.instr;
      end
      default: begin
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.padr        = pc;
    bus.ready       = (pc == '0);
    bus.brz_reg     = bus.instr[3:0];
    bus.issue_valid = iv;
    bus.issue_instr = ii;
    bus.rs_err      = err;
    bus.rs_count    = cnt;
  end
endmodule

// File: tb/tb_prog_seq.sv
// Bench for prog_seq: directed control-flow scenarios plus randomized ROM
// contents and inputs, all checked against a queue-based sequencer model.
module tb_prog_seq;
  localparam int AW    = 13;
  localparam int IW    = 18;
  localparam int RSD   = 4;
  localparam int DEPTH = 1 << AW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_seq_if #(.AW(AW), .IW(IW), .RSD(RSD)) bus ();
  prog_seq #(.AW(AW), .IW(IW), .RSD(RSD)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [IW-1:0] rom [DEPTH];
  logic [15:0]   zmask;

  assign bus.instr    = rom[bus.padr];
  assign bus.brz_zero = (bus.brz_reg == 4'd0) ? 1'b1 : zmask[bus.brz_reg];

  // Reference model state
  int            m_pc;
  int            rs_q[$];
  bit            m_iv;
  logic [IW-1:0] m_ii;
  bit            m_err;
  bit            m_issued;
  logic [IW-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [IW-1:0] enc_brz(input int r, input int off);
    return {5'b11000, off[8:0], r[3:0]};
  endfunction

  function automatic logic [IW-1:0] enc_jmp(input int t);
    return {5'b11010, t[12:0]};
  endfunction

  function automatic logic [IW-1:0] enc_ret();
    return {5'b11100, 13'd0};
  endfunction

  function automatic logic [IW-1:0] rand_plain();
    logic [4:0] op;
    do op = 5'($urandom_range(0, 31));
    while (op == 5'b11000 || op == 5'b11010 || op == 5'b11100);
    return {op, 13'($urandom)};
  endfunction

  function automatic bit reg_zero(input int r);
    return (r == 0) || zmask[r];
  endfunction

  task automatic rom_fill();
    for (int a = 0; a < DEPTH; a++) rom[a] = {5'd1, 13'(a)};
    rom[0] = enc_brz(0, 0);
  endtask

  task automatic m_reset();
    m_pc = 0;
    rs_q.delete();
    m_iv = 0;
    m_ii = '0;
    m_err = 0;
    m_issued = 0;
    exp_q.delete();
  endtask

  // One clock of the sequencer, described by the control-flow rules.
  task automatic model_step(input bit st, input bit sl);
    logic [IW-1:0] w;
    int op, off, tgt;
    w = rom[m_pc];
    op = int'(w[17:13]);
    m_issued = 0;
    if (sl) return;
    if (st && m_pc == 0) begin
      m_pc = 1;
      m_iv = 0;
      return;
    end
    if (op == 24) begin
      off = int'(w[12:4]);
      if (off >= 256) off -= 512;
      m_iv = 0;
      if (reg_zero(int'(w[3:0]))) m_pc = (m_pc + off + DEPTH) % DEPTH;
      else m_pc = (m_pc + 1) % DEPTH;
    end else if (op == 26) begin
      tgt = int'(w[12:0]);
      m_iv = 0;
      if (tgt == 0) begin
        m_pc = 0;
        rs_q.delete();
      end else begin
        rs_q.push_back((m_pc + 1) % DEPTH);
        if (rs_q.size() > RSD) void'(rs_q.pop_front());
        m_pc = tgt;
      end
    end else if (op == 28) begin
      m_iv = 0;
      if (rs_q.size() > 0) m_pc = rs_q.pop_back();
      else begin
        m_pc = 0;
        m_err = 1;
      end
    end else begin
      m_iv = 1;
      m_ii = w;
      m_issued = 1;
      exp_q.push_back(w);
      m_pc = (m_pc + 1) % DEPTH;
    end
  endtask

  task automatic compare();
    check("padr", bus.padr, m_pc);
    check("ready", bus.ready, m_pc == 0);
    check("issue_valid", bus.issue_valid, m_iv);
    check("issue_instr", bus.issue_instr, m_ii);
    check("rs_err", bus.rs_err, m_err);
    check("rs_count", bus.rs_count, rs_q.size());
    if (m_issued && exp_q.size() > 0) check("issue_sb", bus.issue_instr, exp_q.pop_front());
  endtask

  // Driver tasks
  task automatic cycle(input bit st, input bit sl);
    @(negedge clk);
    rst = 1'b0;
    bus.start = st;
    bus.stall = sl;
    #1;
    check("brz_reg", bus.brz_reg, rom[m_pc][3:0]);
    model_step(st, sl);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.stall = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      m_reset();
      compare();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    zmask = '0;
    m_reset();

    // Reset, idle loop, start, call/return, branch loop, stall on a JMP
    rom_fill();
    rom[1]   = 18'h20020;
    rom[14]  = enc_jmp(200);
    rom[16]  = enc_jmp(0);
    rom[203] = enc_brz(6, 4);
    rom[205] = enc_brz(0, -3);
    rom[207] = enc_ret();
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      check("plan_idle_padr", bus.padr, 0);
      check("plan_idle_ready", bus.ready, 1);
    end
    cycle(1'b1, 1'b0);
    check("plan_start_padr", bus.padr, 1);
    check("plan_start_ready", bus.ready, 0);
    cycle(1'b0, 1'b0);
    check("plan_issue_valid", bus.issue_valid, 1);
    check("plan_issue_instr", bus.issue_instr, 18'h20020);
    check("plan_issue_padr", bus.padr, 2);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0);
    check("plan_at_jmp", bus.padr, 14);
    for (int i = 0; i < 3; i++) cycle(i == 1, 1'b1);
    check("plan_stall_padr", bus.padr, 14);
    cycle(1'b0, 1'b0);
    check("plan_call_padr", bus.padr, 200);
    check("plan_call_issue", bus.issue_valid, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("plan_brz_nt", bus.padr, 204);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("plan_brz_back", bus.padr, 202);
    cycle(1'b0, 1'b0);
    zmask[6] = 1'b1;
    cycle(1'b0, 1'b0);
    check("plan_brz_taken", bus.padr, 207);
    cycle(1'b0, 1'b0);
    check("plan_ret_padr", bus.padr, 15);
    check("plan_ret_empty", bus.rs_count, 0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("plan_jmp0_ready", bus.ready, 1);
    cycle(1'b0, 1'b0);

    // Return-stack overflow then underflow
    rom_fill();
    for (int k = 1; k <= 5; k++) begin
      rom[k * 10]     = enc_jmp(k * 10 + 10);
      rom[k * 10 + 1] = enc_ret();
    end
    rom[60] = enc_ret();
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(i[0], 1'b0);
    check("plan_ovf_start", bus.padr, 10);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    check("plan_ovf_deep", bus.padr, 60);
    check("plan_ovf_count", bus.rs_count, RSD);
    cycle(1'b0, 1'b0);
    check("plan_ret51", bus.padr, 51);
    cycle(1'b0, 1'b0);
    check("plan_ret41", bus.padr, 41);
    cycle(1'b0, 1'b0);
    check("plan_ret31", bus.padr, 31);
    cycle(1'b0, 1'b0);
    check("plan_ret21", bus.padr, 21);
    cycle(1'b0, 1'b0);
    check("plan_unf_padr", bus.padr, 0);
    check("plan_unf_err", bus.rs_err, 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("plan_err_sticky", bus.rs_err, 1);
    do_reset(2);
    check("plan_err_cleared", bus.rs_err, 0);

    // Randomized programs and inputs
    for (int a = 0; a < DEPTH; a++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 55)      rom[a] = rand_plain();
      else if (sel < 70) rom[a] = enc_brz($urandom_range(0, 15), $urandom_range(0, 511));
      else if (sel < 85) rom[a] = enc_jmp(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, DEPTH - 1));
      else               rom[a] = enc_ret();
    end
    for (int i = 0; i < 3000; i++) begin
      zmask = 16'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
      else cycle($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
